issue_wakeup_queue: RTL
=======================

// Module: issue_wakeup_queue
// PURPOSE
//  Issue-queue side of the delayed-wakeup protocol: holds dispatched ops until both source operands are woken,
//  selects the oldest ready op, and issues it with issu_en plus a one-hot latency vector wdy to the delayed-wakeup
//  timer. Consumes the timer's wakeup broadcasts (wk_valid/wk_tag) and marks matching source operands ready.
// PARAMETERS
//  ENTRIES  8  queue depth (power of 2, >=2)
//  TAG_W    6  physical register tag width
//  LAT_W    8  width of one-hot execution-latency vector wdy
// PORTS
//  clk            in   1          clock, all state on posedge
//  rst            in   1          asynchronous reset, active-high
//  flush          in   1          discard all entries
//  disp_valid     in   1          dispatch request
//  disp_ready     out  1          queue can accept (count < ENTRIES)
//  disp_src1_tag  in   TAG_W      source 1 tag;  disp_src1_rdy in 1: source 1 already ready
//  disp_src2_tag  in   TAG_W      source 2 tag;  disp_src2_rdy in 1: source 2 already ready
//  disp_dst_tag   in   TAG_W      destination tag
//  disp_lat       in   LAT_W      one-hot latency (bit k = wakeup k+1 cycles after issue)
//  wk_valid       in   1          wakeup broadcast valid (from delayed-wakeup timer)
//  wk_tag         in   TAG_W      tag being woken
//  issu_ready     in   1          downstream accepts issue this cycle
//  issu_en        out  1          an entry is ready and presented
//  issu_dst_tag   out  TAG_W      dst tag of presented entry
//  wdy            out  LAT_W      latency vector of presented entry
//  count          out  clog2(ENTRIES)+1  occupied entries
// BEHAVIOUR
//  - Reset: all entries invalid, age matrix cleared; issu_en=0, issu_dst_tag=0, wdy=0, count=0, disp_ready=1.
//  - Entry: valid, s1_tag/s1_rdy, s2_tag/s2_rdy, dst_tag, lat. ready = valid & s1_rdy & s2_rdy (registered bits).
//  - Dispatch: disp_valid & disp_ready allocates lowest-index free entry at posedge; entry becomes youngest.
//  - disp_ready from registered count only; an issue freeing a slot in the same cycle does not raise it.
//  - Wakeup: wk_valid sets sN_rdy of every valid entry whose sN_tag==wk_tag; also applies to the entry being
//    dispatched the same cycle (bypass), so no wakeup is lost across dispatch.
//  - Select: combinational from registered state; oldest ready entry per age matrix. issu_en/issu_dst_tag/wdy
//    driven from it; issu_dst_tag and wdy are 0 when issu_en=0.
//  - Issue: issu_en & issu_ready frees selected entry at posedge. issu_en & !issu_ready: hold, same entry
//    stays presented unless an older entry becomes ready (outputs may change; no stability guarantee).
//  - Latency: dispatch with both rdy at edge N -> issu_en in cycle after N. Wakeup at edge N -> issu_en next cycle.
//  - count = count + alloc - issue, both may occur same cycle (net 0).
//  - flush: all entries invalid, count=0 at next edge; overrides dispatch, wakeup and issue that cycle.
//  - Reset mid-operation: immediate return to reset state, in-flight wakeups discarded.
//  - disp_lat not one-hot: stored and forwarded unchanged; not checked.
// CONFIGURATION
//  ISSUE_SELF_WAKEUP_EN defined: an issue (issu_en & issu_ready) with wdy==1 also broadcasts issu_dst_tag as a
//   wakeup to queue entries at the same edge (back-to-back single-cycle dependents); combined with wk port (OR).
//  Not defined: readiness changes only via wk_valid/wk_tag and dispatch rdy bits.
// STRUCTURE
//  Package iq_pkg: ENTRIES, TAG_W, LAT_W defaults, CNT_W=clog2(ENTRIES)+1, typedef iq_entry_t (fields above).
//  Sub-module iq_age_select: age matrix update on alloc/free and oldest-ready one-hot + index output.
// TESTING
//  1 Reset: rst=1 async mid-cycle -> issu_en=0, count=0, disp_ready=1 immediately.
//  2 Dispatch src1_rdy=src2_rdy=1, dst=5, lat=8'h04, issu_ready=1 -> next cycle issu_en=1, issu_dst_tag=5,
//    wdy=8'h04; following cycle count=0.
//  3 Dispatch src1=3 not ready; wk_valid tag=3 two cycles later -> issu_en rises cycle after wakeup; wakeup
//    of tag 3 in the dispatch cycle itself -> issu_en the cycle after dispatch.
//  4 Fill 8 entries unready -> disp_ready=0, count=8; wake all -> issue order equals dispatch order (oldest first).
//  5 issu_ready=0 with ready entry -> entry held, count unchanged; flush -> count=0, issu_en=0 next cycle.
//  6 ISSUE_SELF_WAKEUP_EN: A(dst=9,wdy=1) then B(src1=9) -> B issues cycle after A; without macro B waits for wk.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared sizing, entry record and wakeup tag-match helper for the issue wakeup queue.
package iq_pkg;
   localparam int ENTRIES = 8;
   localparam int TAG_W   = 6;
   localparam int LAT_W   = 8;
   localparam int CNT_W   = $clog2(ENTRIES) + 1;
   localparam int IDX_W   = $clog2(ENTRIES);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] s1_tag;
      logic             s1_rdy;
      logic [TAG_W-1:0] s2_tag;
      logic             s2_rdy;
      logic [TAG_W-1:0] dst_tag;
      logic [LAT_W-1:0] lat;
   } iq_entry_t;

   // True when a source tag matches either the timer broadcast or the self-wakeup broadcast.
   function automatic logic tag_hit(input logic [TAG_W-1:0] tag,
                                    input logic wk_v, input logic [TAG_W-1:0] wk_t,
                                    input logic self_v, input logic [TAG_W-1:0] self_t);
      return (wk_v && (tag == wk_t)) || (self_v && (tag == self_t));
   endfunction
endpackage

// File: rtl/iq_age_select.sv
// Age matrix (row i bit j set: entry i is older than entry j) and oldest-ready selection.
module iq_age_select
   import iq_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               alloc,
   input  logic [IDX_W-1:0]   alloc_idx,
   input  logic [ENTRIES-1:0] ready,
   output logic               sel_valid,
   output logic [ENTRIES-1:0] sel_onehot,
   output logic [IDX_W-1:0]   sel_idx
);
   logic [ENTRIES-1:0] age_reg [ENTRIES];

   // A new entry is older than nobody; every other slot becomes older than it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) age_reg[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) age_reg[i] <= '0;
      end else if (alloc) begin
         for (int i = 0; i < ENTRIES; i++) begin
            age_reg[alloc_idx][i] <= 1'b0;
            age_reg[i][alloc_idx] <= (IDX_W'(i) != alloc_idx);
         end
      end
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_sel
         logic [ENTRIES-1:0] older;
         for (gj = 0; gj < ENTRIES; gj++) begin : g_col
            assign older[gj] = age_reg[gj][gi];
         end
         assign sel_onehot[gi] = ready[gi] & ~|(ready & older);
      end
   endgenerate

   assign sel_valid = |ready;

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < ENTRIES; i++)
         if (sel_onehot[i]) sel_idx = sel_idx | IDX_W'(i);
   end
endmodule

// File: rtl/issue_wakeup_queue.sv
// Issue queue for the delayed-wakeup protocol: oldest-ready select, tag wakeup with dispatch bypass.
// Optional ISSUE_SELF_WAKEUP_EN: an issued single-cycle op also wakes its dependents at the issue edge.
module issue_wakeup_queue
   import iq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             disp_valid,
   output logic             disp_ready,
   input  logic [TAG_W-1:0] disp_src1_tag,
   input  logic             disp_src1_rdy,
   input  logic [TAG_W-1:0] disp_src2_tag,
   input  logic             disp_src2_rdy,
   input  logic [TAG_W-1:0] disp_dst_tag,
   input  logic [LAT_W-1:0] disp_lat,
   input  logic             wk_valid,
   input  logic [TAG_W-1:0] wk_tag,
   input  logic             issu_ready,
   output logic             issu_en,
   output logic [TAG_W-1:0] issu_dst_tag,
   output logic [LAT_W-1:0] wdy,
   output logic [CNT_W-1:0] count
);
   iq_entry_t          entries_reg [ENTRIES];
   iq_entry_t          new_entry;
   logic [ENTRIES-1:0] ready_vec, hit1, hit2, sel_onehot;
   logic [IDX_W-1:0]   sel_idx, free_idx;
   logic               sel_valid, alloc, issue_fire, self_wk;

   assign disp_ready = (count != CNT_W'(ENTRIES));
   assign alloc      = disp_valid & disp_ready & ~flush;
   assign issue_fire = issu_en & issu_ready;

`ifdef ISSUE_SELF_WAKEUP_EN
   assign self_wk = issue_fire & (wdy == LAT_W'(1));
`else
   assign self_wk = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
         assign ready_vec[gi] = entries_reg[gi].valid & entries_reg[gi].s1_rdy & entries_reg[gi].s2_rdy;
         assign hit1[gi] = tag_hit(entries_reg[gi].s1_tag, wk_valid, wk_tag, self_wk, issu_dst_tag);
         assign hit2[gi] = tag_hit(entries_reg[gi].s2_tag, wk_valid, wk_tag, self_wk, issu_dst_tag);
      end
   endgenerate

   always_comb begin
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--)
         if (!entries_reg[i].valid) free_idx = IDX_W'(i);
   end

   // Wakeups seen on the dispatch edge are folded into the new entry so none are lost.
   always_comb begin
      new_entry         = '0;
      new_entry.valid   = 1'b1;
      new_entry.s1_tag  = disp_src1_tag;
      new_entry.s1_rdy  = disp_src1_rdy | tag_hit(disp_src1_tag, wk_valid, wk_tag, self_wk, issu_dst_tag);
      new_entry.s2_tag  = disp_src2_tag;
      new_entry.s2_rdy  = disp_src2_rdy | tag_hit(disp_src2_tag, wk_valid, wk_tag, self_wk, issu_dst_tag);
      new_entry.dst_tag = disp_dst_tag;
      new_entry.lat     = disp_lat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) entries_reg[i] <= '0;
         count <= '0;
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) entries_reg[i].valid <= 1'b0;
         count <= '0;
      end else begin
         count <= count + CNT_W'(alloc) - CNT_W'(issue_fire);
         for (int i = 0; i < ENTRIES; i++) begin
            if (alloc && (free_idx == IDX_W'(i))) begin
               entries_reg[i] <= new_entry;
            end else begin
               if (issue_fire && (sel_idx == IDX_W'(i))) entries_reg[i].valid <= 1'b0;
               if (hit1[i]) entries_reg[i].s1_rdy <= 1'b1;
               if (hit2[i]) entries_reg[i].s2_rdy <= 1'b1;
            end
         end
      end
   end

   iq_age_select u_age_select (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .alloc      (alloc),
      .alloc_idx  (free_idx),
      .ready      (ready_vec),
      .sel_valid  (sel_valid),
      .sel_onehot (sel_onehot),
      .sel_idx    (sel_idx)
   );

   assign issu_en      = sel_valid;
   assign issu_dst_tag = sel_valid ? entries_reg[sel_idx].dst_tag : '0;
   assign wdy          = sel_valid ? entries_reg[sel_idx].lat : '0;
endmodule
